// File: rtl/vector_register_file.sv
`default_nettype none
// ============================================================================
// Module   : vector_register_file
// Function : NUM_VREGS x DEPTH element vector register file with independent
//            streaming write and read ports, hazard-interlocked per register.
// Revision : 1.0
// ============================================================================
module vector_register_file #(
   parameter int VECTOR_REG_WIDTH = 64,
   parameter int VECTOR_REG_DEPTH = 64,
   parameter int NUM_VREGS        = 8
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                wr_start,
   output logic                                wr_start_ready,
   input  logic [$clog2(NUM_VREGS)-1:0]        wr_vreg,
   input  logic [$clog2(VECTOR_REG_DEPTH):0]   wr_vl,
   input  logic                                wr_valid,
   output logic                                wr_ready,
   input  logic [VECTOR_REG_WIDTH-1:0]         wr_data,
   input  logic                                wr_mask,
   output logic                                wr_done,
   input  logic                                rd_start,
   output logic                                rd_start_ready,
   input  logic [$clog2(NUM_VREGS)-1:0]        rd_vreg,
   input  logic [$clog2(VECTOR_REG_DEPTH):0]   rd_vl,
   output logic                                rd_valid,
   input  logic                                rd_ready,
   output logic [VECTOR_REG_WIDTH-1:0]         rd_data,
   output logic                                rd_done
);

   localparam int c_RW    = $clog2(NUM_VREGS);
   localparam int c_VW    = $clog2(VECTOR_REG_DEPTH) + 1;
   localparam int c_IW    = c_VW - 1;
   localparam int c_AW    = c_RW + c_IW;
   localparam int c_NELEM = NUM_VREGS * VECTOR_REG_DEPTH;
   localparam logic [c_VW-1:0] c_DEPTH = c_VW'(VECTOR_REG_DEPTH);
   localparam logic [c_VW-1:0] c_ONE   = c_VW'(1);

   typedef enum logic [0:0] {W_IDLE = 1'b0, W_ACTIVE = 1'b1} wr_state_t;
   typedef enum logic [0:0] {R_IDLE = 1'b0, R_ACTIVE = 1'b1} rd_state_t;

   logic [VECTOR_REG_WIDTH-1:0] r_mem [c_NELEM];

   wr_state_t         r_wr_state;
   logic [c_RW-1:0]   r_wr_vreg;
   logic [c_VW-1:0]   r_wr_vl;
   logic [c_VW-1:0]   r_wr_idx;
   logic              r_wr_done;

   rd_state_t         r_rd_state;
   logic [c_RW-1:0]   r_rd_vreg;
   logic [c_VW-1:0]   r_rd_vl;
   logic [c_VW-1:0]   r_rd_idx;
   logic              r_rd_done;

   logic              w_wr_accept;
   logic              w_wr_beat;
   logic              w_wr_last;
   logic [c_VW-1:0]   w_wr_vl_eff;
   logic [c_AW-1:0]   w_wr_addr;
   logic              w_rd_accept;
   logic              w_rd_beat;
   logic              w_rd_last;
   logic [c_VW-1:0]   w_rd_vl_eff;
   logic [c_AW-1:0]   w_rd_addr;
   logic              w_rd_blocked;

   assign w_wr_vl_eff = (wr_vl > c_DEPTH) ? c_DEPTH : wr_vl;
   assign w_rd_vl_eff = (rd_vl > c_DEPTH) ? c_DEPTH : rd_vl;

   assign w_wr_accept = wr_start && wr_start_ready;
   assign w_wr_beat   = (r_wr_state == W_ACTIVE) && wr_valid;
   assign w_wr_last   = (r_wr_idx == (r_wr_vl - c_ONE));
   assign w_wr_addr   = {r_wr_vreg, r_wr_idx[c_IW-1:0]};

   assign w_rd_accept = rd_start && rd_start_ready;
   assign w_rd_beat   = (r_rd_state == R_ACTIVE) && rd_ready;
   assign w_rd_last   = (r_rd_idx == (r_rd_vl - c_ONE));
   assign w_rd_addr   = {r_rd_vreg, r_rd_idx[c_IW-1:0]};

   // A read of a register is held off while a write to it is in flight,
   // through its completion pulse, and when a write to it is accepted now.
   assign w_rd_blocked = (((r_wr_state == W_ACTIVE) || r_wr_done) && (r_wr_vreg == rd_vreg))
                       || (w_wr_accept && (wr_vreg == rd_vreg));

   assign wr_start_ready = reset_n && (r_wr_state == W_IDLE)
                         && !((r_rd_state == R_ACTIVE) && (r_rd_vreg == wr_vreg));
   assign rd_start_ready = reset_n && (r_rd_state == R_IDLE) && !w_rd_blocked;

   assign wr_ready = (r_wr_state == W_ACTIVE);
   assign wr_done  = r_wr_done;
   assign rd_valid = (r_rd_state == R_ACTIVE);
   assign rd_done  = r_rd_done;
   assign rd_data  = (r_rd_state == R_ACTIVE) ? r_mem[w_rd_addr] : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int e = 0; e < c_NELEM; e++) begin
            r_mem[e] <= '0;
         end
      end else if (w_wr_beat && wr_mask) begin
         r_mem[w_wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_state <= W_IDLE;
         r_wr_vreg  <= '0;
         r_wr_vl    <= '0;
         r_wr_idx   <= '0;
         r_wr_done  <= 1'b0;
      end else begin
         r_wr_done <= 1'b0;
         case (r_wr_state)
            W_IDLE: begin
               if (w_wr_accept) begin
                  r_wr_vreg <= wr_vreg;
                  r_wr_vl   <= w_wr_vl_eff;
                  r_wr_idx  <= '0;
                  if (w_wr_vl_eff == '0) r_wr_done  <= 1'b1;
                  else                   r_wr_state <= W_ACTIVE;
               end
            end
            W_ACTIVE: begin
               // Masked beats still advance the element index.
               if (wr_valid) begin
                  if (w_wr_last) begin
                     r_wr_state <= W_IDLE;
                     r_wr_done  <= 1'b1;
                  end else begin
                     r_wr_idx <= r_wr_idx + c_ONE;
                  end
               end
            end
            default: r_wr_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_state <= R_IDLE;
         r_rd_vreg  <= '0;
         r_rd_vl    <= '0;
         r_rd_idx   <= '0;
         r_rd_done  <= 1'b0;
      end else begin
         r_rd_done <= 1'b0;
         case (r_rd_state)
            R_IDLE: begin
               if (w_rd_accept) begin
                  r_rd_vreg <= rd_vreg;
                  r_rd_vl   <= w_rd_vl_eff;
                  r_rd_idx  <= '0;
                  if (w_rd_vl_eff == '0) r_rd_done  <= 1'b1;
                  else                   r_rd_state <= R_ACTIVE;
               end
            end
            R_ACTIVE: begin
               if (w_rd_beat) begin
                  if (w_rd_last) begin
                     r_rd_state <= R_IDLE;
                     r_rd_done  <= 1'b1;
                  end else begin
                     r_rd_idx <= r_rd_idx + c_ONE;
                  end
               end
            end
            default: r_rd_state <= R_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vector_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_register_file
// Function : Directed table-driven bench for vector_register_file.
// Revision : 1.0
// ============================================================================
module tb_vector_register_file;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wr_start, wr_start_ready;
   logic [2:0]  wr_vreg;
   logic [6:0]  wr_vl;
   logic        wr_valid, wr_ready;
   logic [63:0] wr_data;
   logic        wr_mask, wr_done;
   logic        rd_start, rd_start_ready;
   logic [2:0]  rd_vreg;
   logic [6:0]  rd_vl;
   logic        rd_valid, rd_ready;
   logic [63:0] rd_data;
   logic        rd_done;

   vector_register_file #(
      .VECTOR_REG_WIDTH(64),
      .VECTOR_REG_DEPTH(64),
      .NUM_VREGS(8)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .wr_start(wr_start), .wr_start_ready(wr_start_ready),
      .wr_vreg(wr_vreg), .wr_vl(wr_vl),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data), .wr_mask(wr_mask), .wr_done(wr_done),
      .rd_start(rd_start), .rd_start_ready(rd_start_ready),
      .rd_vreg(rd_vreg), .rd_vl(rd_vl),
      .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_done(rd_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]       vreg;
      logic [3:0][63:0] data;
      logic [3:0]       mask;
      logic [3:0][63:0] exp;
   } vec_t;

   vec_t        vt [6];
   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] rd_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " wr_ready"}, wr_ready, 0);
      check({tag, " rd_valid"}, rd_valid, 0);
      check({tag, " wr_done"}, wr_done, 0);
      check({tag, " rd_done"}, rd_done, 0);
      check({tag, " rd_data"}, rd_data, 0);
      check({tag, " wr_start_ready"}, wr_start_ready, 0);
      check({tag, " rd_start_ready"}, rd_start_ready, 0);
   endtask

   task automatic do_write(input logic [2:0] vreg, input logic [6:0] vl,
                           input logic [3:0][63:0] data, input logic [3:0] mask, input string tag);
      @(negedge clk);
      wr_start = 1'b1; wr_vreg = vreg; wr_vl = vl;
      #1 check({tag, " wr_start_ready"}, wr_start_ready, 1);
      @(posedge clk);
      for (int i = 0; i < int'(vl); i++) begin
         @(negedge clk);
         wr_start = 1'b0; wr_valid = 1'b1; wr_data = data[i]; wr_mask = mask[i];
         #1 check({tag, " wr_ready"}, wr_ready, 1);
         @(posedge clk);
      end
      @(negedge clk);
      wr_start = 1'b0; wr_valid = 1'b0;
      #1 check({tag, " wr_done pulse"}, wr_done, 1);
      @(negedge clk);
      #1 check({tag, " wr_done single"}, wr_done, 0);
   endtask

   task automatic start_read(input logic [2:0] vreg, input logic [6:0] vl, input string tag);
      @(negedge clk);
      rd_start = 1'b1; rd_vreg = vreg; rd_vl = vl; rd_ready = 1'b0;
      #1 check({tag, " rd_start_ready"}, rd_start_ready, 1);
      @(posedge clk);
   endtask

   // Gathers handshaked beats into rd_q until rd_done, bounded by max_cyc.
   task automatic collect_read(input bit toggle, input int max_cyc, input string tag);
      bit          got_done = 0;
      bit          prev_stall = 0;
      logic [63:0] prev_data = '0;
      rd_q.delete();
      for (int c = 0; c < max_cyc && !got_done; c++) begin
         @(negedge clk);
         rd_start = 1'b0;
         rd_ready = toggle ? (c % 2 == 0) : 1'b1;
         #1;
         if (c == 0) check({tag, " first beat valid"}, rd_valid, 1);
         if (prev_stall) check({tag, " stall hold"}, rd_data, prev_data);
         if (rd_done) begin
            got_done = 1;
            check({tag, " valid low at done"}, rd_valid, 0);
         end
         if (rd_valid && rd_ready) rd_q.push_back(rd_data);
         prev_stall = rd_valid && !rd_ready;
         prev_data  = rd_data;
      end
      if (!got_done) begin
         n_vec++; n_err++;
         $display("FAIL %s rd_done timeout: got none expected pulse", tag);
      end
      @(negedge clk);
      rd_ready = 1'b0;
      #1 check({tag, " rd_done single"}, rd_done, 0);
   endtask

   task automatic check_all_zero(input int exp_beats, input string tag);
      logic [63:0] acc = '0;
      check({tag, " beat count"}, rd_q.size(), exp_beats);
      foreach (rd_q[i]) acc |= rd_q[i];
      check({tag, " all zero"}, acc, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{3'd1, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 4'b1101, {64'hA3, 64'hA2, 64'h0, 64'hA0}};
      vt[1] = '{3'd4, {64'h44, 64'h33, 64'h22, 64'h11}, 4'b1111, {64'h44, 64'h33, 64'h22, 64'h11}};
      vt[2] = '{3'd4, {64'h88, 64'h77, 64'h66, 64'h55}, 4'b1010, {64'h88, 64'h33, 64'h66, 64'h11}};
      vt[3] = '{3'd7, {64'h0123456789ABCDEF, 64'h8000000000000001, 64'h0, 64'hFFFFFFFFFFFFFFFF}, 4'b1111,
                      {64'h0123456789ABCDEF, 64'h8000000000000001, 64'h0, 64'hFFFFFFFFFFFFFFFF}};
      vt[4] = '{3'd0, {64'h8, 64'h7, 64'h6, 64'h5}, 4'b0000, {64'h0, 64'h0, 64'h0, 64'h0}};
      vt[5] = '{3'd1, {64'hB3, 64'hB2, 64'hB1, 64'hB0}, 4'b0010, {64'hA3, 64'hA2, 64'hB1, 64'hA0}};

      // Reset with both start requests asserted: nothing may be accepted.
      reset_n = 1'b0;
      wr_start = 1'b1; wr_vreg = 3'd0; wr_vl = 7'd4; wr_valid = 1'b0; wr_data = '0; wr_mask = 1'b0;
      rd_start = 1'b1; rd_vreg = 3'd1; rd_vl = 7'd4; rd_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1 check_reset_outputs("reset");
      wr_start = 1'b0; rd_start = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      start_read(3'd3, 7'd64, "rd v3 after reset");
      collect_read(1'b0, 200, "rd v3 after reset");
      check_all_zero(64, "rd v3 after reset");

      for (int k = 0; k < 6; k++) begin
         do_write(vt[k].vreg, 7'd4, vt[k].data, vt[k].mask, $sformatf("vec%0d", k));
         start_read(vt[k].vreg, 7'd4, $sformatf("vec%0d", k));
         collect_read(1'b0, 20, $sformatf("vec%0d", k));
         check($sformatf("vec%0d beat count", k), rd_q.size(), 4);
         for (int i = 0; i < 4 && i < rd_q.size(); i++)
            check($sformatf("vec%0d beat%0d", k, i), rd_q[i], vt[k].exp[i]);
      end

      // Backpressured read of v1.
      start_read(3'd1, 7'd4, "stall rd");
      collect_read(1'b1, 40, "stall rd");
      check("stall rd beat count", rd_q.size(), 4);
      for (int i = 0; i < 4 && i < rd_q.size(); i++)
         check($sformatf("stall rd beat%0d", i), rd_q[i], vt[5].exp[i]);

      // Zero-length write leaves v1 untouched.
      do_write(3'd1, 7'd0, {64'hEE, 64'hEE, 64'hEE, 64'hEE}, 4'b1111, "vl0 wr");
      start_read(3'd1, 7'd4, "vl0 rdback");
      collect_read(1'b0, 20, "vl0 rdback");
      check("vl0 rdback count", rd_q.size(), 4);
      for (int i = 0; i < 4 && i < rd_q.size(); i++)
         check($sformatf("vl0 rdback beat%0d", i), rd_q[i], vt[5].exp[i]);

      // Oversized vector length is clamped to the register depth.
      start_read(3'd3, 7'd100, "rd vl100");
      collect_read(1'b0, 200, "rd vl100");
      check_all_zero(64, "rd vl100");

      // Same-cycle write and read to v2: write wins, read waits it out.
      @(negedge clk);
      wr_start = 1'b1; wr_vreg = 3'd2; wr_vl = 7'd4;
      rd_start = 1'b1; rd_vreg = 3'd2; rd_vl = 7'd4; rd_ready = 1'b0;
      #1;
      check("collide wr_start_ready", wr_start_ready, 1);
      check("collide rd_start_ready", rd_start_ready, 0);
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         wr_start = (i < 2); wr_vreg = 3'd5;
         wr_valid = 1'b1; wr_data = 64'hC0 + 64'(i); wr_mask = 1'b1;
         #1;
         check($sformatf("collide rd held beat%0d", i), rd_start_ready, 0);
         if (i < 2) check($sformatf("busy wr_start_ready beat%0d", i), wr_start_ready, 0);
         @(posedge clk);
      end
      @(negedge clk);
      wr_start = 1'b0; wr_valid = 1'b0;
      #1 check("collide wr_done", wr_done, 1);
      @(negedge clk);
      #1 check("collide rd_start_ready after done", rd_start_ready, 1);
      @(posedge clk);
      collect_read(1'b0, 20, "collide rd");
      check("collide rd count", rd_q.size(), 4);
      for (int i = 0; i < 4 && i < rd_q.size(); i++)
         check($sformatf("collide rd beat%0d", i), rd_q[i], 64'hC0 + 64'(i));

      // Concurrent write v5 and read v4, one beat per cycle each.
      @(negedge clk);
      wr_start = 1'b1; wr_vreg = 3'd5; wr_vl = 7'd4;
      rd_start = 1'b1; rd_vreg = 3'd4; rd_vl = 7'd4;
      #1;
      check("concur wr_start_ready", wr_start_ready, 1);
      check("concur rd_start_ready", rd_start_ready, 1);
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         wr_start = 1'b0; rd_start = 1'b0;
         wr_valid = 1'b1; wr_data = 64'hD0 + 64'(i); wr_mask = 1'b1; rd_ready = 1'b1;
         #1;
         check($sformatf("concur wr_ready%0d", i), wr_ready, 1);
         check($sformatf("concur rd_valid%0d", i), rd_valid, 1);
         check($sformatf("concur rd_data%0d", i), rd_data, vt[2].exp[i]);
         @(posedge clk);
      end
      @(negedge clk);
      wr_valid = 1'b0; rd_ready = 1'b0;
      #1;
      check("concur wr_done", wr_done, 1);
      check("concur rd_done", rd_done, 1);
      start_read(3'd5, 7'd4, "concur rdback");
      collect_read(1'b0, 20, "concur rdback");
      check("concur rdback count", rd_q.size(), 4);
      for (int i = 0; i < 4 && i < rd_q.size(); i++)
         check($sformatf("concur rdback beat%0d", i), rd_q[i], 64'hD0 + 64'(i));

      // Reset in the middle of a 64-beat write to v6.
      @(negedge clk);
      wr_start = 1'b1; wr_vreg = 3'd6; wr_vl = 7'd64;
      #1 check("abort wr_start_ready", wr_start_ready, 1);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         wr_start = 1'b0; wr_valid = 1'b1; wr_data = 64'hDEAD0 + 64'(i); wr_mask = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      wr_data = 64'hDEAD2;
      #1 reset_n = 1'b0;
      #1 check_reset_outputs("abort reset");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1 check($sformatf("abort no wr_done%0d", i), wr_done, 0);
      end
      @(negedge clk);
      wr_valid = 1'b0;
      reset_n = 1'b1;
      #1 check("abort no wr_done after release", wr_done, 0);
      start_read(3'd6, 7'd64, "abort rd v6");
      collect_read(1'b0, 200, "abort rd v6");
      check_all_zero(64, "abort rd v6");
      start_read(3'd1, 7'd4, "abort rd v1");
      collect_read(1'b0, 20, "abort rd v1");
      check_all_zero(4, "abort rd v1");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vector_register_file.md
VECTOR_REGISTER_FILE -- requirements
Module: vector_register_file

Interface
REQ-001 SHALL provide parameter VECTOR_REG_WIDTH, default 64, bits per element.
REQ-002 SHALL provide parameter VECTOR_REG_DEPTH, default 64, elements per vector register.
REQ-003 SHALL provide parameter NUM_VREGS, default 8, number of vector registers. Derived: RW = log2(NUM_VREGS); VW = log2(VECTOR_REG_DEPTH)+1.
REQ-004 SHALL use one clock and an asynchronous, active-low reset. Ports, in order:
 clk  input  1  sole clock, rising edge
 reset_n  input  1  asynchronous active-low reset
 wr_start  input  1  request a write operation
 wr_start_ready  output  1  write request accepted when high with wr_start
 wr_vreg  input  RW  destination register, sampled on accept
 wr_vl  input  VW  vector length, sampled on accept
 wr_valid  input  1  write beat valid
 wr_ready  output  1  write beat accepted
 wr_data  input  VECTOR_REG_WIDTH  element data
 wr_mask  input  1  element enable; 0 leaves element unchanged
 wr_done  output  1  one-cycle pulse, write op complete
 rd_start  input  1  request a read operation
 rd_start_ready  output  1  read request accepted when high with rd_start
 rd_vreg  input  RW  source register, sampled on accept
 rd_vl  input  VW  vector length, sampled on accept
 rd_valid  output  1  read beat valid
 rd_ready  input  1  consumer accepts beat
 rd_data  output  VECTOR_REG_WIDTH  element data
 rd_done  output  1  one-cycle pulse, read op complete

Function
REQ-005 SHALL hold NUM_VREGS x VECTOR_REG_DEPTH elements of VECTOR_REG_WIDTH bits.
REQ-006 SHALL run independent write FSM (W_IDLE, W_ACTIVE) and read FSM (R_IDLE, R_ACTIVE), each with an element index counter.
REQ-007 Write accept: wr_start & wr_start_ready in W_IDLE latches vreg, effective vl, index=0; next state W_ACTIVE (vl>0) or W_IDLE with wr_done pulse next cycle (vl=0).
REQ-008 Effective vl SHALL be min(vl, VECTOR_REG_DEPTH) for both ports.
REQ-009 In W_ACTIVE, wr_ready=1; each wr_valid beat writes wr_data to element[index] if wr_mask=1, then index+1; masked beats still consume an index.
REQ-010 After beat with index=vl-1, write FSM SHALL return to W_IDLE and pulse wr_done the following cycle.
REQ-011 Read accept: rd_start & rd_start_ready in R_IDLE latches vreg, effective vl, index=0; next state R_ACTIVE (vl>0) or R_IDLE with rd_done pulse next cycle (vl=0).
REQ-012 In R_ACTIVE, rd_valid=1 and rd_data=element[index] of latched vreg; first beat valid the cycle after accept.
REQ-013 rd_data SHALL hold stable while rd_valid & !rd_ready; index advances only on rd_valid & rd_ready.
REQ-014 After handshake at index=vl-1, rd_valid SHALL drop next cycle, rd_done pulse that cycle, FSM to R_IDLE.
REQ-015 wr_start_ready SHALL be 1 only in W_IDLE and when no read is active on the requested wr_vreg.
REQ-016 rd_start_ready SHALL be 1 only in R_IDLE and when no write is active on the requested rd_vreg.
REQ-017 Same-cycle wr_start and rd_start to the same vreg, both FSMs idle: write SHALL be accepted, read SHALL be held off (rd_start_ready=0).
REQ-018 Different vregs SHALL read and write concurrently, one beat per cycle each.
REQ-019 Requests while a port's FSM is active SHALL be ignored (start_ready=0); no queueing.

Reset
REQ-020 reset_n low SHALL asynchronously zero all elements, set both FSMs idle, indices 0.
REQ-021 During reset: wr_ready, rd_valid, wr_done, rd_done=0; rd_data=0; wr_start_ready, rd_start_ready=0.
REQ-022 Reset mid-operation SHALL abort it with no done pulse; first accept possible the first cycle after reset_n rises.

Verification
REQ-023 Reset then read v3 vl=64 -> 64 beats of 0, rd_done pulse once.
REQ-024 Write v1 vl=4 data 0xA0..0xA3 mask 1,0,1,1, then read v1 vl=4 -> 0xA0,0x0,0xA2,0xA3.
REQ-025 Read v1 vl=4 with rd_ready toggling 1,0,1,0,... -> rd_data stable across stalls, 4 beats, rd_done after last handshake.
REQ-026 Same-cycle wr_start/rd_start to v2 -> write accepted, rd_start_ready=0 until cycle after wr_done, then read returns written data.
REQ-027 wr_vl=0 -> wr_done one cycle after accept, array unchanged; rd_vl=100 (DEPTH 64) -> exactly 64 beats.
REQ-028 Assert reset_n low at beat 2 of a 64-beat write -> no wr_done, v-target reads all 0 afterward.
